// File: rtl/gpmc_pkg.sv
// -----------------------------------------------------------------------------
// gpmc_pkg
// Shared types and constants for the GPMC slave controller.
//   gpmc_state_t : cycle sequencer states
//   DEF_*        : default geometry and fill word
//   STB_*        : bit positions of the four host strobes in the synchronizer bank
// -----------------------------------------------------------------------------
package gpmc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_CMD   = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_END   = 3'd5
  } gpmc_state_t;

  localparam int          DEF_ADDR_W       = 10;
  // Top latched address bit selects the FIFO window.
  localparam int          DEF_FIFO_WIN_BIT = DEF_ADDR_W - 1;
  localparam logic [15:0] DEF_FILL_WORD    = 16'hDEAD;

  localparam int N_STROBES = 4;
  localparam int STB_CS    = 0;
  localparam int STB_ADV   = 1;
  localparam int STB_WE    = 2;
  localparam int STB_OE    = 3;

endpackage

// File: rtl/gpmc_sync.sv
// -----------------------------------------------------------------------------
// gpmc_sync
// Multi-flop synchronizer for one asynchronous, active-low host strobe, with
// single-cycle rise/fall pulses derived from the synchronized level.
// Ports:
//   clk, rst_n : system clock, async active-low reset (flops reset to 1 = idle)
//   i_async    : raw strobe pin
//   o_sync     : synchronized level
//   o_rise     : 1-clk pulse when o_sync goes 0->1
//   o_fall     : 1-clk pulse when o_sync goes 1->0
// -----------------------------------------------------------------------------
module gpmc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '1;
      r_prev  <= 1'b1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = ~r_prev &  o_sync;
  assign o_fall =  r_prev & ~o_sync;

endmodule

// File: rtl/gpmc_slave_ctrl.sv
// -----------------------------------------------------------------------------
// gpmc_slave_ctrl
// Sequences OMAP GPMC asynchronous address/data-multiplexed cycles (CS4) into
// the clk domain. The word address is latched on nADV and decoded into either
// a register window or a FIFO window (writes push TX, reads pop RX).
// Ports:
//   clk, rst_n              : system clock, async active-low reset
//   i_gpmc_ad_in / o_gpmc_ad_out / o_gpmc_ad_oe : AD bus in / read data / drive enable
//   i_gpmc_cs_n, i_gpmc_adv_n, i_gpmc_we_n, i_gpmc_oe_n : raw host strobes
//   o_reg_addr, o_reg_wdata, o_reg_we, i_reg_rdata      : register file port
//   o_tx_wdata, o_tx_we, i_tx_full, i_tx_afull          : TX FIFO push side
//   i_rx_rdata, o_rx_re, i_rx_empty                     : RX FIFO pop side (FWFT)
//   o_tx_data_ok, o_rx_data_ok : registered FIFO status to host
//   i_err_clr, o_err_tx_ovf, o_err_rx_udf, o_err_proto  : sticky error flags
// -----------------------------------------------------------------------------
module gpmc_slave_ctrl
  import gpmc_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          REG_AW      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] FILL_WORD   = DEF_FILL_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       i_gpmc_ad_in,
  output logic [15:0]       o_gpmc_ad_out,
  output logic              o_gpmc_ad_oe,
  input  logic              i_gpmc_cs_n,
  input  logic              i_gpmc_adv_n,
  input  logic              i_gpmc_we_n,
  input  logic              i_gpmc_oe_n,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [15:0]       o_reg_wdata,
  output logic              o_reg_we,
  input  logic [15:0]       i_reg_rdata,
  output logic [15:0]       o_tx_wdata,
  output logic              o_tx_we,
  input  logic              i_tx_full,
  input  logic              i_tx_afull,
  input  logic [15:0]       i_rx_rdata,
  output logic              o_rx_re,
  input  logic              i_rx_empty,
  output logic              o_tx_data_ok,
  output logic              o_rx_data_ok,
  input  logic              i_err_clr,
  output logic              o_err_tx_ovf,
  output logic              o_err_rx_udf,
  output logic              o_err_proto
);

  // ---------------------------------------------------------------------------
  // Strobe synchronizers
  // ---------------------------------------------------------------------------
  logic [N_STROBES-1:0] w_raw;
  logic [N_STROBES-1:0] w_sync;
  logic [N_STROBES-1:0] w_rise;
  logic [N_STROBES-1:0] w_fall;

  always_comb begin
    w_raw          = '1;
    w_raw[STB_CS]  = i_gpmc_cs_n;
    w_raw[STB_ADV] = i_gpmc_adv_n;
    w_raw[STB_WE]  = i_gpmc_we_n;
    w_raw[STB_OE]  = i_gpmc_oe_n;
  end

  generate
    for (genvar gi = 0; gi < N_STROBES; gi++) begin : g_sync
      gpmc_sync #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (w_raw[gi]),
        .o_sync  (w_sync[gi]),
        .o_rise  (w_rise[gi]),
        .o_fall  (w_fall[gi])
      );
    end
  endgenerate

  // Only cs rise and adv/we/oe falls drive the sequencer.
  logic w_unused;
  assign w_unused = ^{w_rise[STB_OE], w_rise[STB_WE], w_rise[STB_ADV], w_fall[STB_CS]};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  gpmc_state_t       r_state;
  logic [REG_AW-1:0] r_reg_addr;
  logic              r_fifo_win;
  logic [15:0]       r_data;
  logic [15:0]       r_ad_out;
  logic              r_reg_we;
  logic              r_tx_we;
  logic              r_rx_re;
  logic              r_tx_ok;
  logic              r_rx_ok;
  logic              r_err_ovf;
  logic              r_err_udf;
  logic              r_err_proto;

  // Next-state / next-value signals
  gpmc_state_t       w_state_next;
  logic [REG_AW-1:0] w_reg_addr_next;
  logic              w_fifo_win_next;
  logic [15:0]       w_data_next;
  logic [15:0]       w_ad_out_next;
  logic              w_reg_we_next;
  logic              w_tx_we_next;
  logic              w_rx_re_next;
  logic              w_set_ovf;
  logic              w_set_udf;
  logic              w_set_proto;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Strobes and read data are registered on the transition into WRITE/READ,
  // so each strobe is high for exactly the single WRITE/READ cycle and the
  // read word reaches the pins SYNC_STAGES+1 clocks after nOE falls.
  always_comb begin
    w_state_next    = r_state;
    w_reg_addr_next = r_reg_addr;
    w_fifo_win_next = r_fifo_win;
    w_data_next     = r_data;
    w_ad_out_next   = r_ad_out;
    w_reg_we_next   = 1'b0;
    w_tx_we_next    = 1'b0;
    w_rx_re_next    = 1'b0;
    w_set_ovf       = 1'b0;
    w_set_udf       = 1'b0;
    w_set_proto     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Edge, not level: after a mid-cycle reset we wait for a fresh nADV.
        if (w_fall[STB_ADV] && !w_sync[STB_CS]) begin
          w_state_next = S_ADDR;
        end
      end

      S_ADDR: begin
        if (w_rise[STB_CS]) begin
          w_state_next = S_IDLE;
        end else begin
          w_reg_addr_next = i_gpmc_ad_in[REG_AW-1:0];
          w_fifo_win_next = i_gpmc_ad_in[ADDR_W-1];
          w_state_next    = S_CMD;
        end
      end

      S_CMD: begin
        if (w_rise[STB_CS]) begin
          w_state_next = S_IDLE;
        end else if (!w_sync[STB_WE] && !w_sync[STB_OE]) begin
          w_set_proto  = 1'b1;
          w_state_next = S_END;
        end else if (w_fall[STB_WE]) begin
          w_data_next  = i_gpmc_ad_in;
          w_state_next = S_WRITE;
          if (r_fifo_win) begin
            if (!i_tx_full) begin
              w_tx_we_next = 1'b1;
            end else begin
              w_set_ovf = 1'b1;
            end
          end else begin
            w_reg_we_next = 1'b1;
          end
        end else if (w_fall[STB_OE]) begin
          w_state_next = S_READ;
          if (r_fifo_win) begin
            if (!i_rx_empty) begin
              w_ad_out_next = i_rx_rdata;
              w_rx_re_next  = 1'b1;
            end else begin
              w_ad_out_next = FILL_WORD;
              w_set_udf     = 1'b1;
            end
          end else begin
            w_ad_out_next = i_reg_rdata;
          end
        end
      end

      S_WRITE: w_state_next = S_END;

      S_READ:  w_state_next = S_END;

      S_END: begin
        if (w_sync[STB_CS]) begin
          w_state_next = S_IDLE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_addr  <= '0;
      r_fifo_win  <= 1'b0;
      r_data      <= '0;
      r_ad_out    <= '0;
      r_reg_we    <= 1'b0;
      r_tx_we     <= 1'b0;
      r_rx_re     <= 1'b0;
      r_tx_ok     <= 1'b0;
      r_rx_ok     <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_reg_addr  <= w_reg_addr_next;
      r_fifo_win  <= w_fifo_win_next;
      r_data      <= w_data_next;
      r_ad_out    <= w_ad_out_next;
      r_reg_we    <= w_reg_we_next;
      r_tx_we     <= w_tx_we_next;
      r_rx_re     <= w_rx_re_next;
      r_tx_ok     <= ~i_tx_afull;
      r_rx_ok     <= ~i_rx_empty;
      // Sticky flags: a new error in the clearing cycle is kept.
      r_err_ovf   <= w_set_ovf   | (r_err_ovf   & ~i_err_clr);
      r_err_udf   <= w_set_udf   | (r_err_udf   & ~i_err_clr);
      r_err_proto <= w_set_proto | (r_err_proto & ~i_err_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Drive enable follows the raw pins so the bus turns around without sync delay.
  assign o_gpmc_ad_oe  = ~i_gpmc_cs_n & ~i_gpmc_oe_n;
  assign o_gpmc_ad_out = r_ad_out;
  assign o_reg_addr    = r_reg_addr;
  assign o_reg_wdata   = r_data;
  assign o_reg_we      = r_reg_we;
  assign o_tx_wdata    = r_data;
  assign o_tx_we       = r_tx_we;
  assign o_rx_re       = r_rx_re;
  assign o_tx_data_ok  = r_tx_ok;
  assign o_rx_data_ok  = r_rx_ok;
  assign o_err_tx_ovf  = r_err_ovf;
  assign o_err_rx_udf  = r_err_udf;
  assign o_err_proto   = r_err_proto;

endmodule

// File: tb/tb_gpmc_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpmc_slave_ctrl
// Directed bench for gpmc_slave_ctrl: a table of single GPMC accesses with
// hand-computed results, followed by hand-written multi-cycle sequences
// (abort, protocol error + clear, reset in the middle of a write).
// -----------------------------------------------------------------------------
module tb_gpmc_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_gpmc_ad_in;
  logic [15:0] o_gpmc_ad_out;
  logic        o_gpmc_ad_oe;
  logic        i_gpmc_cs_n, i_gpmc_adv_n, i_gpmc_we_n, i_gpmc_oe_n;
  logic [3:0]  o_reg_addr;
  logic [15:0] o_reg_wdata;
  logic        o_reg_we;
  logic [15:0] i_reg_rdata;
  logic [15:0] o_tx_wdata;
  logic        o_tx_we;
  logic        i_tx_full, i_tx_afull;
  logic [15:0] i_rx_rdata;
  logic        o_rx_re;
  logic        i_rx_empty;
  logic        o_tx_data_ok, o_rx_data_ok;
  logic        i_err_clr;
  logic        o_err_tx_ovf, o_err_rx_udf, o_err_proto;

  always #5 clk = ~clk;

  gpmc_slave_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_gpmc_ad_in  (i_gpmc_ad_in),
    .o_gpmc_ad_out (o_gpmc_ad_out),
    .o_gpmc_ad_oe  (o_gpmc_ad_oe),
    .i_gpmc_cs_n   (i_gpmc_cs_n),
    .i_gpmc_adv_n  (i_gpmc_adv_n),
    .i_gpmc_we_n   (i_gpmc_we_n),
    .i_gpmc_oe_n   (i_gpmc_oe_n),
    .o_reg_addr    (o_reg_addr),
    .o_reg_wdata   (o_reg_wdata),
    .o_reg_we      (o_reg_we),
    .i_reg_rdata   (i_reg_rdata),
    .o_tx_wdata    (o_tx_wdata),
    .o_tx_we       (o_tx_we),
    .i_tx_full     (i_tx_full),
    .i_tx_afull    (i_tx_afull),
    .i_rx_rdata    (i_rx_rdata),
    .o_rx_re       (o_rx_re),
    .i_rx_empty    (i_rx_empty),
    .o_tx_data_ok  (o_tx_data_ok),
    .o_rx_data_ok  (o_rx_data_ok),
    .i_err_clr     (i_err_clr),
    .o_err_tx_ovf  (o_err_tx_ovf),
    .o_err_rx_udf  (o_err_rx_udf),
    .o_err_proto   (o_err_proto)
  );

  // Register file stand-in: read data is a fixed pattern with the address in the low nibble.
  assign i_reg_rdata = {12'hC0D, o_reg_addr};

  // Strobe monitors, sampled mid-cycle.
  int          cnt_reg_we = 0;
  int          cnt_tx_we  = 0;
  int          cnt_rx_re  = 0;
  logic [3:0]  cap_reg_addr  = '0;
  logic [15:0] cap_reg_wdata = '0;
  logic [15:0] cap_tx_wdata  = '0;

  always @(negedge clk) begin
    if (o_reg_we) begin
      cnt_reg_we    <= cnt_reg_we + 1;
      cap_reg_addr  <= o_reg_addr;
      cap_reg_wdata <= o_reg_wdata;
    end
    if (o_tx_we) begin
      cnt_tx_we    <= cnt_tx_we + 1;
      cap_tx_wdata <= o_tx_wdata;
    end
    if (o_rx_re) begin
      cnt_rx_re <= cnt_rx_re + 1;
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic addr_phase(input logic [15:0] a);
    @(negedge clk);
    i_gpmc_cs_n  = 1'b0;
    i_gpmc_adv_n = 1'b0;
    i_gpmc_ad_in = a;
    repeat (6) @(negedge clk);
    i_gpmc_adv_n = 1'b1;
  endtask

  task automatic close_cycle();
    @(negedge clk);
    i_gpmc_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic gpmc_write(input logic [15:0] a, input logic [15:0] d);
    addr_phase(a);
    @(negedge clk);
    i_gpmc_ad_in = d;
    i_gpmc_we_n  = 1'b0;
    repeat (6) @(negedge clk);
    i_gpmc_we_n = 1'b1;
    close_cycle();
  endtask

  // Samples the AD bus and drive enable SYNC_STAGES+1 = 3 clocks after nOE falls.
  task automatic gpmc_read(input logic [15:0] a, output logic [15:0] ad, output logic oe);
    addr_phase(a);
    @(negedge clk);
    i_gpmc_ad_in = 16'h0000;
    i_gpmc_oe_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ad = o_gpmc_ad_out;
    oe = o_gpmc_ad_oe;
    repeat (4) @(negedge clk);
    i_gpmc_oe_n = 1'b1;
    close_cycle();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        tx_full;
    logic        rx_empty;
    logic [15:0] rx_head;
    int          e_reg_we;
    int          e_tx_we;
    int          e_rx_re;
    logic [3:0]  e_raddr;
    logic [15:0] e_val;   // write: expected strobe data; read: expected AD value
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          b_reg, b_tx, b_rx;
    logic [15:0] rd;
    logic        rd_oe;

    rst_n        = 1'b1;
    i_gpmc_ad_in = '0;
    i_gpmc_cs_n  = 1'b1;
    i_gpmc_adv_n = 1'b1;
    i_gpmc_we_n  = 1'b1;
    i_gpmc_oe_n  = 1'b1;
    i_tx_full    = 1'b0;
    i_tx_afull   = 1'b0;
    i_rx_rdata   = '0;
    i_rx_empty   = 1'b1;
    i_err_clr    = 1'b0;

    //            wr    addr      data      full  empty head      rwe tx rx raddr val       ovf   udf
    vecs[0] = '{1'b1, 16'h0005, 16'h1234, 1'b0, 1'b1, 16'h0000, 1, 0, 0, 4'h5, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0200, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 0, 1, 0, 4'h0, 16'hBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0200, 16'hCAFE, 1'b1, 1'b1, 16'h0000, 0, 0, 0, 4'h0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h00A5, 0, 0, 1, 4'h0, 16'h00A5, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b1, 16'h1111, 0, 0, 0, 4'hF, 16'hDEAD, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h2222, 0, 0, 0, 4'h3, 16'hC0D3, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h01FF, 16'h0F0F, 1'b0, 1'b1, 16'h0000, 1, 0, 0, 4'hF, 16'h0F0F, 1'b0, 1'b0};

    // ---------------- Reset state ----------------
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ad_out",   {16'h0, o_gpmc_ad_out}, 32'h0);
    check("rst ad_oe",    {31'h0, o_gpmc_ad_oe}, 32'h0);
    check("rst strobes",  {29'h0, o_reg_we, o_tx_we, o_rx_re}, 32'h0);
    check("rst data_ok",  {30'h0, o_tx_data_ok, o_rx_data_ok}, 32'h0);
    check("rst errs",     {29'h0, o_err_tx_ovf, o_err_rx_udf, o_err_proto}, 32'h0);
    check("rst reg_addr", {28'h0, o_reg_addr}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("tx_data_ok afull=0", {31'h0, o_tx_data_ok}, 32'h1);
    check("rx_data_ok empty=1", {31'h0, o_rx_data_ok}, 32'h0);
    i_tx_afull = 1'b1;
    i_rx_empty = 1'b0;
    repeat (2) @(negedge clk);
    check("tx_data_ok afull=1", {31'h0, o_tx_data_ok}, 32'h0);
    check("rx_data_ok empty=0", {31'h0, o_rx_data_ok}, 32'h1);
    i_tx_afull = 1'b0;
    i_rx_empty = 1'b1;

    // ---------------- Table of single accesses ----------------
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      i_tx_full  = vecs[i].tx_full;
      i_rx_empty = vecs[i].rx_empty;
      i_rx_rdata = vecs[i].rx_head;
      pulse_clr();
      @(negedge clk);
      b_reg = cnt_reg_we;
      b_tx  = cnt_tx_we;
      b_rx  = cnt_rx_re;
      if (vecs[i].wr) begin
        gpmc_write(vecs[i].addr, vecs[i].data);
        if (vecs[i].e_reg_we != 0) begin
          check($sformatf("v%0d reg_addr", i), {28'h0, cap_reg_addr}, {28'h0, vecs[i].e_raddr});
          check($sformatf("v%0d reg_wdata", i), {16'h0, cap_reg_wdata}, {16'h0, vecs[i].e_val});
        end
        if (vecs[i].e_tx_we != 0) begin
          check($sformatf("v%0d tx_wdata", i), {16'h0, cap_tx_wdata}, {16'h0, vecs[i].e_val});
        end
      end else begin
        gpmc_read(vecs[i].addr, rd, rd_oe);
        check($sformatf("v%0d ad_out@nOE+3", i), {16'h0, rd}, {16'h0, vecs[i].e_val});
        check($sformatf("v%0d ad_oe", i), {31'h0, rd_oe}, 32'h1);
        check($sformatf("v%0d reg_addr", i), {28'h0, o_reg_addr}, {28'h0, vecs[i].e_raddr});
      end
      check($sformatf("v%0d reg_we count", i), cnt_reg_we - b_reg, vecs[i].e_reg_we);
      check($sformatf("v%0d tx_we count", i),  cnt_tx_we - b_tx,   vecs[i].e_tx_we);
      check($sformatf("v%0d rx_re count", i),  cnt_rx_re - b_rx,   vecs[i].e_rx_re);
      check($sformatf("v%0d err_tx_ovf", i), {31'h0, o_err_tx_ovf}, {31'h0, vecs[i].e_ovf});
      check($sformatf("v%0d err_rx_udf", i), {31'h0, o_err_rx_udf}, {31'h0, vecs[i].e_udf});
      check($sformatf("v%0d err_proto", i),  {31'h0, o_err_proto},  32'h0);
    end
    check("ad_oe after read", {31'h0, o_gpmc_ad_oe}, 32'h0);
    check("ad_out holds", {16'h0, o_gpmc_ad_out}, 32'h0000C0D3);
    i_tx_full = 1'b0;

    // ---------------- Abort: CS4 high before nWE ----------------
    b_reg = cnt_reg_we;
    b_tx  = cnt_tx_we;
    addr_phase(16'h0006);
    repeat (2) @(negedge clk);
    i_gpmc_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    i_gpmc_ad_in = 16'h9999;
    i_gpmc_we_n  = 1'b0;          // stray nWE with CS4 deasserted
    repeat (6) @(negedge clk);
    i_gpmc_we_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort reg_we count", cnt_reg_we - b_reg, 0);
    check("abort tx_we count",  cnt_tx_we - b_tx,   0);
    gpmc_write(16'h0009, 16'hA5A5);   // only completes if the sequencer is back in IDLE
    check("post-abort reg_we count", cnt_reg_we - b_reg, 1);
    check("post-abort reg_addr",  {28'h0, cap_reg_addr},  32'h9);
    check("post-abort reg_wdata", {16'h0, cap_reg_wdata}, 32'hA5A5);

    // ---------------- Protocol error, flag accumulation, err_clr ----------------
    i_tx_full = 1'b1;
    gpmc_write(16'h0200, 16'h0BAD);
    i_tx_full  = 1'b0;
    i_rx_empty = 1'b1;
    gpmc_read(16'h0200, rd, rd_oe);
    check("udf read ad_out", {16'h0, rd}, 32'hDEAD);
    b_reg = cnt_reg_we;
    b_tx  = cnt_tx_we;
    b_rx  = cnt_rx_re;
    addr_phase(16'h0004);
    @(negedge clk);
    i_gpmc_we_n = 1'b0;
    i_gpmc_oe_n = 1'b0;
    repeat (6) @(negedge clk);
    i_gpmc_we_n = 1'b1;
    i_gpmc_oe_n = 1'b1;
    close_cycle();
    check("proto strobes", (cnt_reg_we - b_reg) + (cnt_tx_we - b_tx) + (cnt_rx_re - b_rx), 0);
    check("all flags set", {29'h0, o_err_tx_ovf, o_err_rx_udf, o_err_proto}, 32'h7);
    pulse_clr();
    @(negedge clk);
    check("flags after clr", {29'h0, o_err_tx_ovf, o_err_rx_udf, o_err_proto}, 32'h0);

    // ---------------- Reset in the middle of a write ----------------
    b_reg = cnt_reg_we;
    addr_phase(16'h0007);
    @(negedge clk);
    i_gpmc_ad_in = 16'h7777;
    i_gpmc_we_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst ad_out",   {16'h0, o_gpmc_ad_out}, 32'h0);
    check("midrst tx_ok",    {31'h0, o_tx_data_ok}, 32'h0);
    check("midrst reg_addr", {28'h0, o_reg_addr}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;                  // CS4 and nWE still low
    repeat (8) @(negedge clk);
    i_gpmc_we_n = 1'b1;
    close_cycle();
    check("midrst reg_we count", cnt_reg_we - b_reg, 0);
    gpmc_write(16'h000A, 16'h5555);
    check("recovery reg_we count", cnt_reg_we - b_reg, 1);
    check("recovery reg_addr",  {28'h0, cap_reg_addr},  32'hA);
    check("recovery reg_wdata", {16'h0, cap_reg_wdata}, 32'h5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
